twos_comp_serial: RTL
=====================

TWOS_COMP_SERIAL -- requirements
Module: twos_comp_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits; only 16 is required to be supported.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request a conversion; accepted only while ready=1.
REQ-005 SHALL have port mode, input, 1: 0 = negate (~x+1), 1 = absolute value; sampled on acceptance.
REQ-006 SHALL have port din, input, 16: operand, two's complement; sampled on acceptance.
REQ-007 SHALL have port ready, output, 1: high only in IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when dout/ovf are updated.
REQ-009 SHALL have port dout, output, 16: result, held until the next completion or reset.
REQ-010 SHALL have port ovf, output, 1: result not representable; held with dout.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: ready=1; start=1 at a rising edge latches din, mode, invert_en and moves to RUN with bit counter=0 and seen_one=0.
REQ-013 invert_en SHALL be 1 when mode=0, and din[15] when mode=1; if invert_en=0 the result equals din.
REQ-014 RUN SHALL process one bit per cycle, LSB first: result bit = b XOR (invert_en AND seen_one); then seen_one |= b.
REQ-015 RUN SHALL last exactly 16 cycles; on the edge where the counter equals 15 the FSM moves to DONE.
REQ-016 DONE SHALL last one cycle with done=1 and dout/ovf already showing the new result, then return to IDLE.
REQ-017 Latency: start accepted at edge E0 -> done high during the cycle after edge E16; next start is accepted no earlier than E18.
REQ-018 start while in RUN or DONE SHALL be ignored, with no queueing.
REQ-019 ovf SHALL be 1 iff invert_en=1 and din=0x8000 (result 0x8000); negate of 0x0000 yields 0x0000 with ovf=0.
REQ-020 dout and ovf SHALL NOT change outside the DONE entry edge or reset.

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, ready=1, done=0, dout=0x0000, ovf=0, counter=0, seen_one=0, shift registers=0.
REQ-022 Reset during RUN or DONE SHALL abort the conversion with no done pulse; operation resumes from IDLE on the first edge after release.

Structure
REQ-023 Shared package alu_pkg SHALL hold the WIDTH constant (16), the state enum (IDLE/RUN/DONE) and the mode encodings (MODE_NEG=0, MODE_ABS=1).
REQ-024 The block SHALL be a single module with no sub-modules; the counter, shift registers and FSM stay inline.

Verification
REQ-025 Negate din=0x0168 (360) with mode=0 -> dout=0xFE98, ovf=0, done pulse exactly 17 cycles after the accept edge.
REQ-026 Absolute value of din=0xFE98 with mode=1 -> dout=0x0168, ovf=0; absolute value of din=0x0005 -> dout=0x0005, ovf=0, same latency.
REQ-027 Negate 0x8000 -> dout=0x8000, ovf=1; negate 0x0000 -> dout=0x0000, ovf=0.
REQ-028 start pulsed with din=0x1234 during RUN cycle 5 of a 0x0168 negation -> single done pulse, dout=0xFE98, ready stays 0 until after DONE.
REQ-029 rst_n low during RUN cycle 8 -> dout=0, ovf=0, ready=1 with no done pulse; a following negation of 0x0001 -> 0xFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width, FSM state and mode encodings for the serial ALU blocks
package alu_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_NEG = 1'b0;
    localparam logic MODE_ABS = 1'b1;

endpackage

// File: rtl/twos_comp_serial.sv
// rtl/twos_comp_serial.sv - bit-serial two's complement negate / absolute value, LSB first
module twos_comp_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             ovf
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             seen_q;
    logic             inv_q;
    logic             ready_q;
    logic             done_q;
    logic             ovf_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] dout_q;

    logic             res_bit_d;
    logic [WIDTH-1:0] res_d;

    // Bits below and including the first 1 pass through; everything above flips.
    always_comb begin
        res_bit_d = sh_q[0] ^ (inv_q & seen_q);
        res_d     = {res_bit_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            inv_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sh_q    <= '0;
            res_q   <= '0;
            dout_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sh_q    <= din;
                        res_q   <= '0;
                        inv_q   <= (mode == MODE_ABS) ? din[WIDTH-1] : 1'b1;
                        cnt_q   <= '0;
                        seen_q  <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sh_q   <= sh_q >> 1;
                    res_q  <= res_d;
                    seen_q <= seen_q | sh_q[0];
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        dout_q  <= res_d;
                        ovf_q   <= inv_q && (res_d == MIN_NEG);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign dout  = dout_q;
    assign ovf   = ovf_q;

endmodule
